// File: rtl/regbank_stack.sv
// ============================================================================
// Module   : regbank_stack
// Purpose  : Parametrised two-read-port register bank, r0 = 0, top register is
//            a bounds-checked hardware stack pointer with sticky fault flags.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module regbank_stack #(
    parameter int                 DATA_W      = 32,
    parameter int                 ADDR_W      = 5,
    parameter logic [DATA_W-1:0]  SP_RESET    = 'h0000_0FFC,
    parameter logic [DATA_W-1:0]  STACK_BASE  = 'h0000_0FFC,
    parameter logic [DATA_W-1:0]  STACK_LIMIT = 'h0000_0800,
    parameter int unsigned        SP_STEP     = 4,
    parameter bit                 BYPASS      = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    input  logic              rd1_sp,
    output logic [DATA_W-1:0] rd_data1,
    output logic [DATA_W-1:0] rd_data2,
    input  logic [1:0]        sp_op,
    input  logic [DATA_W-1:0] sp_load,
    output logic [DATA_W-1:0] sp_out,
    output logic              stack_ovf,
    output logic              stack_unf,
    input  logic              err_clr
);

    localparam int                DEPTH  = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] SP_IDX = ADDR_W'(DEPTH - 1);
    localparam logic [DATA_W:0]   STEP_X = (DATA_W+1)'(SP_STEP);

    localparam logic [1:0] OP_NONE = 2'b00;
    localparam logic [1:0] OP_PUSH = 2'b01;
    localparam logic [1:0] OP_POP  = 2'b10;
    localparam logic [1:0] OP_LOAD = 2'b11;

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DATA_W-1:0] sp;
    logic [DATA_W-1:0] sp_next;
    logic [DATA_W:0]   sp_dec;
    logic [DATA_W:0]   sp_inc;
    logic              ovf_set;
    logic              unf_set;
    logic              gp_write;

    assign sp     = regs[SP_IDX];
    assign sp_out = sp;

    // One extra bit on each side of the SP arithmetic exposes borrow/carry.
    always_comb begin
        sp_dec  = {1'b0, sp} - STEP_X;
        sp_inc  = {1'b0, sp} + STEP_X;
        sp_next = sp;
        ovf_set = 1'b0;
        unf_set = 1'b0;
        case (sp_op)
            OP_PUSH: begin
                if (sp_dec[DATA_W] || (sp_dec[DATA_W-1:0] < STACK_LIMIT))
                    ovf_set = 1'b1;
                else
                    sp_next = sp_dec[DATA_W-1:0];
            end
            OP_POP: begin
                if (sp_inc[DATA_W] || (sp_inc[DATA_W-1:0] > STACK_BASE))
                    unf_set = 1'b1;
                else
                    sp_next = sp_inc[DATA_W-1:0];
            end
            OP_LOAD: sp_next = sp_load;
            default: sp_next = sp;
        endcase
    end

    // A stack operation owns the SP slot; a general write to it that cycle is dropped.
    assign gp_write = wr_en && (wr_addr != '0) &&
                      !((wr_addr == SP_IDX) && (sp_op != OP_NONE));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++)
                regs[i] <= (i == DEPTH - 1) ? SP_RESET : '0;
            stack_ovf <= 1'b0;
            stack_unf <= 1'b0;
        end else begin
            if (gp_write)
                regs[wr_addr] <= wr_data;
            if (sp_op != OP_NONE)
                regs[SP_IDX] <= sp_next;
            stack_ovf <= ovf_set | (stack_ovf & ~err_clr);
            stack_unf <= unf_set | (stack_unf & ~err_clr);
        end
    end

    for (genvar p = 0; p < 2; p++) begin : g_rd_port
        logic [ADDR_W-1:0] eff_addr;
        logic [DATA_W-1:0] val;

        if (p == 0) begin : g_addr1
            assign eff_addr = rd1_sp ? SP_IDX : rd_addr1;
            assign rd_data1 = val;
        end else begin : g_addr2
            assign eff_addr = rd_addr2;
            assign rd_data2 = val;
        end

        // SP bypass outranks the write-data bypass on the SP index.
        always_comb begin
            val = regs[eff_addr];
            if (eff_addr == '0)
                val = '0;
            else if (BYPASS && (eff_addr == SP_IDX) && (sp_op != OP_NONE))
                val = sp_next;
            else if (BYPASS && wr_en && (eff_addr == wr_addr))
                val = wr_data;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_regbank_stack.sv
// ============================================================================
// Module   : tb_regbank_stack
// Purpose  : Self-checking bench for regbank_stack: directed cases plus random
//            traffic compared every cycle against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_regbank_stack;

    localparam longint LIMIT = 'h800;
    localparam longint BASE  = 'hFFC;

    logic        clk = 1'b0;
    logic        reset;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [4:0]  rd_addr1;
    logic [4:0]  rd_addr2;
    logic        rd1_sp;
    logic [31:0] rd_data1;
    logic [31:0] rd_data2;
    logic [1:0]  sp_op;
    logic [31:0] sp_load;
    logic [31:0] sp_out;
    logic        stack_ovf;
    logic        stack_unf;
    logic        err_clr;

    int errors = 0;
    int checks = 0;
    bit checking = 1'b0;

    logic [31:0] mem [32];
    bit          m_ovf;
    bit          m_unf;

    regbank_stack dut (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_addr1  (rd_addr1),
        .rd_addr2  (rd_addr2),
        .rd1_sp    (rd1_sp),
        .rd_data1  (rd_data1),
        .rd_data2  (rd_data2),
        .sp_op     (sp_op),
        .sp_load   (sp_load),
        .sp_out    (sp_out),
        .stack_ovf (stack_ovf),
        .stack_unf (stack_unf),
        .err_clr   (err_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Stack rules evaluated with wide signed integers so borrow/carry show up as range errors.
    function automatic void sp_eval(input logic [31:0] sp, input logic [1:0] op,
                                    input logic [31:0] ld, output logic [31:0] nsp,
                                    output bit ovf, output bit unf);
        longint t;
        nsp = sp;
        ovf = 1'b0;
        unf = 1'b0;
        case (op)
            2'd1: begin
                t = longint'(sp) - 4;
                if (t < LIMIT) ovf = 1'b1; else nsp = t[31:0];
            end
            2'd2: begin
                t = longint'(sp) + 4;
                if (t > BASE) unf = 1'b1; else nsp = t[31:0];
            end
            2'd3: nsp = ld;
            default: nsp = sp;
        endcase
    endfunction

    function automatic logic [31:0] exp_read(input logic [4:0] a);
        logic [31:0] nsp;
        bit o, u;
        if (a == 5'd0) return 32'h0;
        if (a == 5'd31 && sp_op != 2'd0) begin
            sp_eval(mem[31], sp_op, sp_load, nsp, o, u);
            return nsp;
        end
        if (wr_en && a == wr_addr) return wr_data;
        return mem[a];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) mem[i] = 32'h0;
        mem[31] = 32'h0000_0FFC;
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    task automatic model_update();
        logic [31:0] nsp;
        bit o, u;
        sp_eval(mem[31], sp_op, sp_load, nsp, o, u);
        if (wr_en && wr_addr != 5'd0 && !(wr_addr == 5'd31 && sp_op != 2'd0))
            mem[wr_addr] = wr_data;
        if (sp_op != 2'd0) mem[31] = nsp;
        m_ovf = o ? 1'b1 : (err_clr ? 1'b0 : m_ovf);
        m_unf = u ? 1'b1 : (err_clr ? 1'b0 : m_unf);
    endtask

    always @(negedge clk) begin
        if (checking && !reset) begin
            check("sp_out", sp_out, mem[31]);
            check("stack_ovf", 32'(stack_ovf), 32'(m_ovf));
            check("stack_unf", 32'(stack_unf), 32'(m_unf));
            check("rd_data1", rd_data1, exp_read(rd1_sp ? 5'd31 : rd_addr1));
            check("rd_data2", rd_data2, exp_read(rd_addr2));
        end
    end

    task automatic idle();
        wr_en    = 1'b0;
        wr_addr  = 5'd0;
        wr_data  = 32'h0;
        rd_addr1 = 5'd0;
        rd_addr2 = 5'd0;
        rd1_sp   = 1'b0;
        sp_op    = 2'd0;
        sp_load  = 32'h0;
        err_clr  = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        if (!reset) model_update();
        #1;
    endtask

    initial begin
        int r;
        reset = 1'b1;
        idle();
        repeat (2) @(posedge clk);
        model_reset();
        #1 reset = 1'b0;
        checking = 1'b1;

        // Reset contents on every address
        check("rst_sp_out", sp_out, 32'h0000_0FFC);
        check("rst_ovf", 32'(stack_ovf), 32'h0);
        check("rst_unf", 32'(stack_unf), 32'h0);
        for (int a = 0; a < 32; a++) begin
            rd_addr1 = 5'(a);
            rd_addr2 = 5'(31 - a);
            #2;
            check("rst_rd1", rd_data1, (a == 31) ? 32'h0000_0FFC : 32'h0);
            tick();
        end

        // Write bypass and register 0
        idle();
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h1234_5678; rd_addr2 = 5'd3;
        #2 check("byp_rd2", rd_data2, 32'h1234_5678);
        tick();
        idle(); rd_addr2 = 5'd3;
        #2 check("wr_rd2", rd_data2, 32'h1234_5678);
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFF_FFFF; rd_addr1 = 5'd0;
        #2 check("r0_byp", rd_data1, 32'h0);
        tick();
        idle();
        #2 check("r0_rd", rd_data1, 32'h0);

        // Three pushes from reset, SP bypass on the first
        sp_op = 2'd1; rd1_sp = 1'b1;
        #2 check("sp_byp", rd_data1, 32'h0000_0FF8);
        tick();
        check("push1", sp_out, 32'h0000_0FF8);
        rd1_sp = 1'b0;
        tick();
        check("push2", sp_out, 32'h0000_0FF4);
        tick();
        check("push3", sp_out, 32'h0000_0FF0);
        idle();

        // Bounds and sticky flags
        sp_op = 2'd3; sp_load = 32'h0000_0800; tick();
        sp_op = 2'd1; tick(); idle();
        check("ovf_sp", sp_out, 32'h0000_0800);
        check("ovf_flag", 32'(stack_ovf), 32'h1);
        sp_op = 2'd3; sp_load = 32'h0000_0FFC; tick();
        sp_op = 2'd2; tick(); idle();
        check("unf_sp", sp_out, 32'h0000_0FFC);
        check("unf_flag", 32'(stack_unf), 32'h1);
        err_clr = 1'b1; tick(); idle();
        check("clr_ovf", 32'(stack_ovf), 32'h0);
        check("clr_unf", 32'(stack_unf), 32'h0);
        sp_op = 2'd3; sp_load = 32'h0000_0800; tick();
        sp_op = 2'd1; err_clr = 1'b1; tick(); idle();
        check("clr_vs_ovf", 32'(stack_ovf), 32'h1);

        // Collisions
        sp_op = 2'd3; sp_load = 32'h0000_0FFC; tick();
        sp_op = 2'd1; wr_en = 1'b1; wr_addr = 5'd31; wr_data = 32'hAAAA_AAAA; tick(); idle();
        check("coll_sp", sp_out, 32'h0000_0FF8);
        sp_op = 2'd2; wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h0000_0055; tick(); idle();
        check("pop_wr_sp", sp_out, 32'h0000_0FFC);
        rd_addr2 = 5'd7;
        #2 check("pop_wr_r7", rd_data2, 32'h0000_0055);
        tick();

        // Asynchronous reset in the middle of a write
        idle();
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'h0000_DEAD;
        #1;
        checking = 1'b0;
        reset = 1'b1;
        model_reset();
        @(posedge clk);
        #1 idle();
        reset = 1'b0;
        #1 checking = 1'b1;
        rd_addr1 = 5'd5;
        #1 check("rst_mid_r5", rd_data1, 32'h0);
        check("rst_mid_sp", sp_out, 32'h0000_0FFC);
        check("rst_mid_ovf", 32'(stack_ovf), 32'h0);
        tick();

        // Random traffic against the model
        for (int n = 0; n < 1500; n++) begin
            wr_en    = 1'($urandom_range(0, 1));
            wr_addr  = 5'($urandom);
            wr_data  = $urandom;
            rd_addr1 = 5'($urandom);
            rd_addr2 = ($urandom_range(0, 3) == 0) ? wr_addr : 5'($urandom);
            rd1_sp   = ($urandom_range(0, 3) == 0);
            r = int'($urandom_range(0, 19));
            sp_op    = (r < 8) ? 2'd1 : (r < 14) ? 2'd2 : (r < 15) ? 2'd3 : 2'd0;
            case ($urandom_range(0, 6))
                0: sp_load = 32'h0000_0800;
                1: sp_load = 32'h0000_0804;
                2: sp_load = 32'h0000_0FFC;
                3: sp_load = 32'h0000_0FF8;
                4: sp_load = 32'h0000_0000;
                5: sp_load = 32'hFFFF_FFFC;
                default: sp_load = $urandom;
            endcase
            err_clr  = ($urandom_range(0, 15) == 0);
            tick();
        end

        idle();
        tick();
        checking = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
